axi_burst_traffic_gen: RTL

Parametrised AXI4-full burst master that generates INCR write bursts, read bursts, or write-then-read-verify traffic towards an AXI4 slave. It is the configurable successor to the fixed 16-beat, 32-bit master used in the top-level master/slave loopback. Data width, burst length and ID width are set by parameters; burst count, mode, base address and data seed are set at run time. It reports completion, response errors and read-compare mismatches.

---
 rtl/axi_burst_traffic_gen.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_traffic_gen.sv
//==============================================================================
// Module      : axi_burst_traffic_gen
// Description : AXI4 INCR burst master issuing write, read or write-then-verify
//               traffic with an incrementing data pattern and read checking.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module axi_burst_traffic_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 1,
    parameter int BURST_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic                  i_sysclk,
    input  logic                  i_sysrst,
    input  logic                  i_start,
    input  logic [1:0]            i_mode,
    input  logic [CNT_W-1:0]      i_num_bursts,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [DATA_W-1:0]     i_seed,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_resp_err,
    output logic [CNT_W-1:0]      o_err_count,
    output logic [ADDR_W-1:0]     o_first_err_addr,
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_W-1:0]       m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_W-1:0]       m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int c_bytes       = DATA_W / 8;
    localparam int c_burst_bytes = BURST_LEN * c_bytes;
    localparam int c_size        = $clog2(c_bytes);
    localparam int c_beat_w      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [c_beat_w-1:0] c_last_beat  = c_beat_w'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0]   c_off_mask   = ADDR_W'(c_burst_bytes - 1);
    localparam logic [ADDR_W-1:0]   c_burst_step = ADDR_W'(c_burst_bytes);
    localparam logic [1:0]          c_mode_wr    = 2'd0;
    localparam logic [1:0]          c_mode_rd    = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WA   = 3'd1,
        S_WD   = 3'd2,
        S_WB   = 3'd3,
        S_RA   = 3'd4,
        S_RD   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [1:0]          r_mode;
    logic [CNT_W-1:0]    r_num;
    logic [CNT_W-1:0]    r_burst_cnt;
    logic [ADDR_W-1:0]   r_base;
    logic [DATA_W-1:0]   r_seed;
    logic [ADDR_W-1:0]   r_burst_addr;
    logic [DATA_W-1:0]   r_pattern;
    logic [c_beat_w-1:0] r_beat;
    logic                r_busy;
    logic                r_done;
    logic                r_resp_err;
    logic [CNT_W-1:0]    r_err_count;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_err_seen;

    logic w_start_ok;
    logic w_last_burst;
    logic w_beat_last;
    logic w_w_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_unused;

    assign w_start_ok   = (r_state == S_IDLE) && i_start;
    assign w_last_burst = (r_burst_cnt == r_num - CNT_W'(1));
    assign w_beat_last  = (r_beat == c_last_beat);
    assign w_w_hs       = (r_state == S_WD) && m_axi_wready;
    assign w_b_hs       = (r_state == S_WB) && m_axi_bvalid;
    assign w_r_hs       = (r_state == S_RD) && m_axi_rvalid;
    assign w_unused     = ^{m_axi_bid, m_axi_rid};

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_num_bursts == '0)
                        w_next = S_DONE;
                    else if (i_mode == c_mode_rd)
                        w_next = S_RA;
                    else
                        w_next = S_WA;
                end
            end
            S_WA: if (m_axi_awready) w_next = S_WD;
            S_WD: if (m_axi_wready && w_beat_last) w_next = S_WB;
            S_WB: begin
                if (m_axi_bvalid) begin
                    if (!w_last_burst)
                        w_next = S_WA;
                    else if (r_mode == c_mode_wr)
                        w_next = S_DONE;
                    else
                        w_next = S_RA;
                end
            end
            S_RA: if (m_axi_arready) w_next = S_RD;
            S_RD: begin
                if (m_axi_rvalid && m_axi_rlast)
                    w_next = w_last_burst ? S_DONE : S_RA;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_mode           <= '0;
            r_num            <= '0;
            r_burst_cnt      <= '0;
            r_base           <= '0;
            r_seed           <= '0;
            r_burst_addr     <= '0;
            r_pattern        <= '0;
            r_beat           <= '0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_resp_err       <= 1'b0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_err_seen       <= 1'b0;
        end else begin
            // Registered flags put o_done and the o_busy drop one cycle after DONE.
            r_done <= (r_state == S_DONE);
            if (r_state == S_DONE)
                r_busy <= 1'b0;

            if (w_start_ok) begin
                r_busy           <= 1'b1;
                r_mode           <= i_mode;
                r_num            <= i_num_bursts;
                r_base           <= i_base_addr & ~c_off_mask;
                r_seed           <= i_seed;
                r_burst_cnt      <= '0;
                r_burst_addr     <= i_base_addr & ~c_off_mask;
                r_pattern        <= i_seed;
                r_beat           <= '0;
                r_resp_err       <= 1'b0;
                r_err_count      <= '0;
                r_first_err_addr <= '0;
                r_err_seen       <= 1'b0;
            end

            if (w_w_hs) begin
                r_pattern <= r_pattern + DATA_W'(1);
                r_beat    <= w_beat_last ? '0 : r_beat + c_beat_w'(1);
            end

            if (w_b_hs) begin
                if (m_axi_bresp != 2'b00)
                    r_resp_err <= 1'b1;
                if (w_last_burst) begin
                    // Read phase replays the write sequence from the start.
                    r_burst_cnt  <= '0;
                    r_burst_addr <= r_base;
                    r_pattern    <= r_seed;
                end else begin
                    r_burst_cnt  <= r_burst_cnt + CNT_W'(1);
                    r_burst_addr <= r_burst_addr + c_burst_step;
                end
            end

            if (w_r_hs) begin
                if (m_axi_rdata != r_pattern) begin
                    if (r_err_count != {CNT_W{1'b1}})
                        r_err_count <= r_err_count + CNT_W'(1);
                    if (!r_err_seen) begin
                        r_err_seen       <= 1'b1;
                        r_first_err_addr <= r_burst_addr + (ADDR_W'(r_beat) << c_size);
                    end
                end
                if ((m_axi_rresp != 2'b00) || (m_axi_rlast != w_beat_last))
                    r_resp_err <= 1'b1;
                r_pattern <= r_pattern + DATA_W'(1);
                if (m_axi_rlast) begin
                    r_beat       <= '0;
                    r_burst_cnt  <= r_burst_cnt + CNT_W'(1);
                    r_burst_addr <= r_burst_addr + c_burst_step;
                end else begin
                    r_beat <= w_beat_last ? '0 : r_beat + c_beat_w'(1);
                end
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_resp_err       = r_resp_err;
    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;

    assign m_axi_awid    = '0;
    assign m_axi_awaddr  = r_burst_addr;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'(c_size);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = (r_state == S_WA);

    assign m_axi_wdata   = r_pattern;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = w_beat_last;
    assign m_axi_wvalid  = (r_state == S_WD);
    assign m_axi_bready  = (r_state == S_WB);

    assign m_axi_arid    = '0;
    assign m_axi_araddr  = r_burst_addr;
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = 3'(c_size);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arqos   = 4'b0000;
    assign m_axi_arvalid = (r_state == S_RA);
    assign m_axi_rready  = (r_state == S_RD);

endmodule

`default_nettype wire
